uart_frame_parser: RTL
======================

Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes each received byte (rx-done flag plus 8-bit parallel data) and assembles fixed 5-byte command frames: SYNC, ADDR, DATA_HI, DATA_LO, CHK.
- On a valid frame, issues a one-cycle register-write strobe with address and 16-bit data to the test-register bank.
- Bad checksums and inter-byte timeouts are reported and counted.

Parameters:
- SYNC_BYTE, 8'h55, frame start marker.
- TIMEOUT_CLKS, 110000, max clocks between bytes inside a frame (about 2 byte-times at 9600 baud, 50 MHz).
- CNT_W, 17, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CLKS.

Ports:
- I_clk  input  1  system 50 MHz clock
- I_rst  input  1  asynchronous, active-high reset
- I_rx_done  input  1  receiver byte-complete flag; may be high for one or more cycles
- I_para_data  input  8  received byte; valid whenever I_rx_done is high
- O_wr_en  output  1  one-cycle register-write strobe
- O_wr_addr  output  8  write address; held until next write
- O_wr_data  output  16  write data {DATA_HI, DATA_LO}; held until next write
- O_frame_err  output  1  one-cycle pulse on checksum error or timeout
- O_err_code  output  2  2'b01 checksum, 2'b10 timeout; holds last value
- O_err_cnt  output  8  saturating error count
- O_busy  output  1  high whenever state is not S_IDLE

Behaviour:
- Reset (async, I_rst=1):
  - State goes to S_IDLE.
  - All outputs, the byte registers, the timeout counter and the edge-detect register go to 0.
  - A frame in progress is discarded with no error flagged.
- Byte acceptance:
  - A byte is accepted in the cycle where I_rx_done=1 and its registered copy is 0 (rising edge).
  - I_para_data is sampled in that same cycle.
  - A level held high for several cycles yields exactly one byte.
- FSM transitions on each accepted byte:
  - S_IDLE: byte==SYNC_BYTE goes to S_ADDR. Any other byte is silently dropped; no error.
  - S_ADDR: latch addr, go to S_DHI.
  - S_DHI: latch dhi, go to S_DLO.
  - S_DLO: latch dlo, go to S_CHK.
  - S_CHK: compare byte against addr^dhi^dlo, then go to S_IDLE.
- SYNC_BYTE values received inside a frame are treated as ordinary data; there is no resync.
- Checksum match: on the next cycle O_wr_en=1 for exactly 1 cycle, with O_wr_addr/O_wr_data updated in that same cycle. Latency is 1 clock from CHK byte acceptance.
- Checksum mismatch: on the next cycle O_frame_err=1, O_err_code=2'b01, O_err_cnt increments; no write.
- Timeout:
  - Counter clears on every accepted byte and counts every clock while state is not S_IDLE.
  - When the counter reaches TIMEOUT_CLKS-1 with no byte in that cycle, the next cycle gives: state S_IDLE, O_frame_err pulse, O_err_code=2'b10, O_err_cnt increments.
  - A byte arriving in the expiry cycle wins: it is accepted, the counter clears, and no timeout occurs.
- O_err_cnt saturates at 8'hFF; no wrap.
- O_wr_en and O_frame_err are never high in the same cycle.
- Back-to-back frames: a SYNC accepted in the cycle after the CHK byte is handled normally; no idle gap is required.

Decomposition:
- Shared package uart_pkg:
  - state encodings S_IDLE..S_CHK (3-bit)
  - error codes ERR_NONE=2'b00, ERR_CHK=2'b01, ERR_TMO=2'b10
  - default SYNC_BYTE and FRAME_LEN=5
- One natural sub-module, uart_byte_edge: the rising-edge detector with data sample, producing a clean 1-cycle byte_valid plus byte. The FSM, timeout counter and error counter stay in the top.

Test Plan:
- Valid frame: send 55 12 AB CD 74 (12^AB^CD=74) -> exactly one O_wr_en pulse 1 clk after the last byte; O_wr_addr=8'h12, O_wr_data=16'hABCD; O_frame_err stays 0.
- Bad checksum: send 55 12 AB CD 00 -> O_frame_err pulse, O_err_code=01, O_err_cnt=1, no O_wr_en; then send 55 01 02 03 00 -> write addr 01, data 0203.
- Timeout: send 55 12, then idle TIMEOUT_CLKS clocks -> O_frame_err with code 10, O_busy falls, O_err_cnt increments; a byte landing exactly in the expiry cycle produces no error.
- Noise and held rx_done: send 00 FF 55 55 00 00 55 with I_rx_done held 4 cycles per byte -> leading bytes ignored; frame addr 55, data 0000, chk 55 gives a write to 55 with data 0000; each byte counted exactly once.
- Reset mid-frame: assert I_rst after 55 12 AB -> all outputs 0, state S_IDLE; a following full valid frame is written correctly with no spurious error.
- Saturation: inject 260 checksum-error frames -> O_err_cnt stops at FF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame parser: FSM states,
// error codes, frame constants and small helper functions.
package uart_pkg;

  // Parser states, one per expected frame byte
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  // Error codes reported on O_err_code
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // Frame layout: SYNC, ADDR, DATA_HI, DATA_LO, CHK
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
  localparam int         FRAME_LEN         = 5;

  // Frame checksum is the XOR of the three payload bytes
  function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return addr ^ dhi ^ dlo;
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_parser_byte_edge.sv
// Rising-edge detector on the receiver's byte-complete flag. A flag held
// high for several cycles yields exactly one byte_valid pulse; the data
// byte is passed through from the same cycle as the pulse.
module uart_byte_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] para_data,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic rx_done_reg;

  // Remember last cycle's flag level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_reg <= 1'b0;
    end else begin
      rx_done_reg <= rx_done;
    end
  end

  assign byte_valid = rx_done & ~rx_done_reg;
  assign byte_data  = para_data;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 5-byte command frames (SYNC, ADDR, DATA_HI, DATA_LO, CHK) from
// received UART bytes, issues a one-cycle register write on a good frame,
// and reports/counts checksum errors and inter-byte timeouts.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 110000,
  parameter int         CNT_W        = 17
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_rx_done,
  input  logic [7:0]  I_para_data,
  output logic        O_wr_en,
  output logic [7:0]  O_wr_addr,
  output logic [15:0] O_wr_data,
  output logic        O_frame_err,
  output logic [1:0]  O_err_code,
  output logic [7:0]  O_err_cnt,
  output logic        O_busy
);

  // Last counter value before the frame is abandoned
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic       byte_valid;
  logic [7:0] byte_data;

  state_t           state_reg,    state_next;
  logic [7:0]       addr_reg,     addr_next;
  logic [7:0]       dhi_reg,      dhi_next;
  logic [7:0]       dlo_reg,      dlo_next;
  logic [CNT_W-1:0] tmo_cnt_reg,  tmo_cnt_next;
  logic             wr_en_reg,    wr_en_next;
  logic [7:0]       wr_addr_reg,  wr_addr_next;
  logic [15:0]      wr_data_reg,  wr_data_next;
  logic             frame_err_reg, frame_err_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic [7:0]       err_cnt_reg,  err_cnt_next;

  uart_byte_edge u_byte_edge (
    .clk        (I_clk),
    .rst        (I_rst),
    .rx_done    (I_rx_done),
    .para_data  (I_para_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  // State, frame bytes, timeout counter and registered outputs
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= 8'd0;
      dhi_reg       <= 8'd0;
      dlo_reg       <= 8'd0;
      tmo_cnt_reg   <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= 8'd0;
      wr_data_reg   <= 16'd0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
      err_cnt_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      dhi_reg       <= dhi_next;
      dlo_reg       <= dlo_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      frame_err_reg <= frame_err_next;
      err_code_reg  <= err_code_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  // Next-state logic: an accepted byte always takes priority over timeout
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    dhi_next       = dhi_reg;
    dlo_next       = dlo_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    frame_err_next = 1'b0;
    err_code_next  = err_code_reg;
    err_cnt_next   = err_cnt_reg;

    if (byte_valid) begin
      tmo_cnt_next = '0;
      case (state_reg)
        S_IDLE: begin
          // Non-SYNC bytes between frames are line noise and dropped quietly
          if (byte_data == SYNC_BYTE) begin
            state_next = S_ADDR;
          end
        end
        S_ADDR: begin
          addr_next  = byte_data;
          state_next = S_DHI;
        end
        S_DHI: begin
          dhi_next   = byte_data;
          state_next = S_DLO;
        end
        S_DLO: begin
          dlo_next   = byte_data;
          state_next = S_CHK;
        end
        S_CHK: begin
          state_next = S_IDLE;
          if (byte_data == frame_chk(addr_reg, dhi_reg, dlo_reg)) begin
            wr_en_next   = 1'b1;
            wr_addr_next = addr_reg;
            wr_data_next = {dhi_reg, dlo_reg};
          end else begin
            frame_err_next = 1'b1;
            err_code_next  = ERR_CHK;
            err_cnt_next   = sat_inc8(err_cnt_reg);
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end else if (state_reg != S_IDLE) begin
      if (tmo_cnt_reg == TMO_LAST) begin
        state_next     = S_IDLE;
        tmo_cnt_next   = '0;
        frame_err_next = 1'b1;
        err_code_next  = ERR_TMO;
        err_cnt_next   = sat_inc8(err_cnt_reg);
      end else begin
        tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
      end
    end else begin
      tmo_cnt_next = '0;
    end
  end

  assign O_wr_en     = wr_en_reg;
  assign O_wr_addr   = wr_addr_reg;
  assign O_wr_data   = wr_data_reg;
  assign O_frame_err = frame_err_reg;
  assign O_err_code  = err_code_reg;
  assign O_err_cnt   = err_cnt_reg;
  assign O_busy      = (state_reg != S_IDLE);

endmodule
